// File: rtl/fifo_sync.sv
// -----------------------------------------------------------------------------
// fifo_sync: single-clock parametrised FIFO for pixel/line buffering.
//
// Features: occupancy count, almost-full/almost-empty thresholds, sticky
// overflow/underflow flags, one-cycle pushed_last/popped_last pulses, and a
// choice of registered read (FWFT=0) or first-word-fall-through (FWFT=1).
//
// Ports:
//   clock        in   rising-edge clock for all logic
//   reset_n      in   synchronous active-low reset
//   enable       in   1 = push/pop honoured, 0 = state frozen
//   clear        in   synchronous active-high flush (memory contents kept)
//   fifo_ready   out  1 = out of reset/clear and usable
//   push         in   write request
//   in_data      in   write data
//   pop          in   read request
//   out_data     out  read data
//   out_valid    out  out_data qualifier
//   count        out  occupancy 0..DEPTH
//   full, empty  out  count==DEPTH / count==0
//   almost_full  out  count >= ALMOST_FULL_LEVEL
//   almost_empty out  count <= ALMOST_EMPTY_LEVEL
//   overflow     out  sticky: push rejected because full
//   underflow    out  sticky: pop rejected because empty
//   pushed_last  out  pulse: an accepted push made the FIFO full
//   popped_last  out  pulse: an accepted pop made the FIFO empty
// -----------------------------------------------------------------------------
module fifo_sync #(
    parameter int FIFO_SIZE          = 3,
    parameter int DATA_WIDTH         = 8,
    parameter int ALMOST_FULL_LEVEL  = 6,
    parameter int ALMOST_EMPTY_LEVEL = 1,
    parameter int FWFT               = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  clear,
    output logic                  fifo_ready,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic [FIFO_SIZE:0]    count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  pushed_last,
    output logic                  popped_last
);

    localparam int                 DEPTH   = 1 << FIFO_SIZE;
    localparam logic [FIFO_SIZE:0] DEPTH_C = DEPTH[FIFO_SIZE:0];
    localparam logic [FIFO_SIZE:0] AF_C    = ALMOST_FULL_LEVEL[FIFO_SIZE:0];
    localparam logic [FIFO_SIZE:0] AE_C    = ALMOST_EMPTY_LEVEL[FIFO_SIZE:0];
    localparam logic [FIFO_SIZE:0] CNT_ONE = 1;
    localparam logic [FIFO_SIZE-1:0] PTR_ONE = 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [FIFO_SIZE-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_SIZE-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FIFO_SIZE:0]    count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  pushed_last_q, pushed_last_d;
    logic                  popped_last_q, popped_last_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  ready_q;

    logic full_w, empty_w;
    logic push_acc, pop_acc;

    // Flags come straight from the registered count, so full/empty never
    // depend on comparing pointers and cannot disagree with count.
    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        push_acc      = 1'b0;
        pop_acc       = 1'b0;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        overflow_d    = overflow_q;
        underflow_d   = underflow_q;
        pushed_last_d = 1'b0;
        popped_last_d = 1'b0;
        rd_data_d     = rd_data_q;
        rd_valid_d    = rd_valid_q;

        if (enable) begin
            pop_acc  = pop & ~empty_w;
            // A pop in the same cycle frees a slot, so a full FIFO still
            // takes the push.
            push_acc = push & (~full_w | pop_acc);

            if (pop & empty_w)    underflow_d = 1'b1;
            if (push & ~push_acc) overflow_d  = 1'b1;

            if (push_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_ONE;

            case ({push_acc, pop_acc})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase

            pushed_last_d = push_acc & ~pop_acc & (count_q == DEPTH_C - CNT_ONE);
            popped_last_d = pop_acc & ~push_acc & (count_q == CNT_ONE);

            // Registered-read path: valid only in the cycle after a pop.
            rd_valid_d = pop_acc;
            if (pop_acc) rd_data_d = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            pushed_last_q <= 1'b0;
            popped_last_q <= 1'b0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            ready_q       <= 1'b0;
        end else if (clear) begin
            // Flush everything except the last read word.
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            pushed_last_q <= 1'b0;
            popped_last_q <= 1'b0;
            rd_valid_q    <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
            pushed_last_q <= pushed_last_d;
            popped_last_q <= popped_last_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            ready_q       <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; pointers and count define which
    // entries are live, so clearing the array would only cost logic.
    always_ff @(posedge clock) begin
        if (reset_n && !clear && push_acc) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // In FWFT mode the head word is shown combinationally; it is forced to
    // zero while empty so stale memory never appears on the bus.
    assign out_data     = (FWFT != 0) ? (empty_w ? '0 : mem_q[rd_ptr_q]) : rd_data_q;
    assign out_valid    = (FWFT != 0) ? ~empty_w : rd_valid_q;

    assign fifo_ready   = ready_q;
    assign count        = count_q;
    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign pushed_last  = pushed_last_q;
    assign popped_last  = popped_last_q;

endmodule

// File: tb/tb_fifo_sync.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync: self-checking bench for fifo_sync. Two instances share one
// input stimulus: u_std (registered read) and u_fwft (first-word-fall-through).
// A queue-based reference model predicts every output after each edge; a
// table of hand-derived vectors and directed sequences cover the corner cases,
// followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_fifo_sync;

    localparam int FS    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << FS;
    localparam int AFL   = 6;
    localparam int AEL   = 1;

    logic          clock = 1'b0;
    logic          reset_n, enable, clear, push, pop;
    logic [DW-1:0] in_data;

    logic          rdy0, ov0, full0, empty0, af0, ae0, ovf0, unf0, pl0, ppl0;
    logic [DW-1:0] od0;
    logic [FS:0]   cnt0;
    logic          rdy1, ov1, full1, empty1, af1, ae1, ovf1, unf1, pl1, ppl1;
    logic [DW-1:0] od1;
    logic [FS:0]   cnt1;

    always #5 clock = ~clock;

    fifo_sync #(.FIFO_SIZE(FS), .DATA_WIDTH(DW), .ALMOST_FULL_LEVEL(AFL),
                .ALMOST_EMPTY_LEVEL(AEL), .FWFT(0)) u_std (
        .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear),
        .fifo_ready(rdy0), .push(push), .in_data(in_data), .pop(pop),
        .out_data(od0), .out_valid(ov0), .count(cnt0), .full(full0),
        .empty(empty0), .almost_full(af0), .almost_empty(ae0),
        .overflow(ovf0), .underflow(unf0), .pushed_last(pl0), .popped_last(ppl0)
    );

    fifo_sync #(.FIFO_SIZE(FS), .DATA_WIDTH(DW), .ALMOST_FULL_LEVEL(AFL),
                .ALMOST_EMPTY_LEVEL(AEL), .FWFT(1)) u_fwft (
        .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear),
        .fifo_ready(rdy1), .push(push), .in_data(in_data), .pop(pop),
        .out_data(od1), .out_valid(ov1), .count(cnt1), .full(full1),
        .empty(empty1), .almost_full(af1), .almost_empty(ae1),
        .overflow(ovf1), .underflow(unf1), .pushed_last(pl1), .popped_last(ppl1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] m_q[$];
    logic          m_ovf, m_unf, m_pl, m_ppl, m_rdy, m_valid;
    logic [DW-1:0] m_data;

    task automatic model_edge();
        int  n;
        bit  pop_ok, push_ok;
        if (!reset_n) begin
            m_q.delete();
            {m_ovf, m_unf, m_pl, m_ppl, m_rdy, m_valid} = '0;
            m_data = '0;
        end else if (clear) begin
            m_q.delete();
            {m_ovf, m_unf, m_pl, m_ppl, m_rdy, m_valid} = '0;
        end else begin
            m_rdy = 1'b1;
            m_pl  = 1'b0;
            m_ppl = 1'b0;
            if (enable) begin
                n       = m_q.size();
                pop_ok  = pop && n > 0;
                push_ok = push && (n < DEPTH || pop_ok);
                if (pop && n == 0)   m_unf = 1'b1;
                if (push && !push_ok) m_ovf = 1'b1;
                m_valid = pop_ok;
                if (pop_ok)  m_data = m_q.pop_front();
                if (push_ok) m_q.push_back(in_data);
                m_pl  = push_ok && n == DEPTH - 1 && m_q.size() == DEPTH;
                m_ppl = pop_ok && n == 1 && m_q.size() == 0;
            end
        end
    endtask

    task automatic check_model();
        int            n;
        logic [DW-1:0] head;
        n    = m_q.size();
        head = (n > 0) ? m_q[0] : '0;
        check("std.count", cnt0, n);
        check("std.full", full0, n == DEPTH);
        check("std.empty", empty0, n == 0);
        check("std.almost_full", af0, n >= AFL);
        check("std.almost_empty", ae0, n <= AEL);
        check("std.overflow", ovf0, m_ovf);
        check("std.underflow", unf0, m_unf);
        check("std.pushed_last", pl0, m_pl);
        check("std.popped_last", ppl0, m_ppl);
        check("std.fifo_ready", rdy0, m_rdy);
        check("std.out_valid", ov0, m_valid);
        check("std.out_data", od0, m_data);
        check("fwft.count", cnt1, n);
        check("fwft.overflow", ovf1, m_ovf);
        check("fwft.underflow", unf1, m_unf);
        check("fwft.pushed_last", pl1, m_pl);
        check("fwft.popped_last", ppl1, m_ppl);
        check("fwft.fifo_ready", rdy1, m_rdy);
        check("fwft.out_valid", ov1, n > 0);
        check("fwft.out_data", od1, head);
    endtask

    // Apply one cycle of inputs, advance the model at the edge, compare after.
    task automatic step(input logic rst_i, input logic clr_i, input logic en_i,
                        input logic psh_i, input logic pp_i, input logic [DW-1:0] d_i);
        reset_n = rst_i;
        clear   = clr_i;
        enable  = en_i;
        push    = psh_i;
        pop     = pp_i;
        in_data = d_i;
        @(posedge clock);
        model_edge();
        #1;
        check_model();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          rst_n, clr, en, psh, pp;
        logic [DW-1:0] din;
        int            cnt;
        logic          full, empty, af, ae, pl, ppl, valid;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic rst_n, input logic psh, input logic pp,
                                input logic [DW-1:0] din, input int cnt,
                                input logic pl, input logic ppl, input logic valid,
                                input logic [DW-1:0] dout);
        vec_t v;
        v.rst_n = rst_n; v.clr = 1'b0; v.en = 1'b1; v.psh = psh; v.pp = pp;
        v.din = din; v.cnt = cnt;
        v.full = (cnt == 8); v.empty = (cnt == 0);
        v.af = (cnt >= 6); v.ae = (cnt <= 1);
        v.pl = pl; v.ppl = ppl; v.valid = valid; v.dout = dout;
        return v;
    endfunction

    logic [DW-1:0] last_word;

    initial begin
        reset_n = 1'b0; clear = 1'b0; enable = 1'b1;
        push = 1'b0; pop = 1'b0; in_data = '0;
        m_q.delete();
        {m_ovf, m_unf, m_pl, m_ppl, m_rdy, m_valid} = '0;
        m_data = '0;

        // Reset, fill 0x11..0x18, drain, one idle cycle.
        vecs[0] = mk(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 8; i++)
            vecs[i] = mk(1'b1, 1'b1, 1'b0, 8'(8'h10 + i), i, i == 8, 1'b0, 1'b0, 8'h00);
        for (int j = 1; j <= 8; j++)
            vecs[8 + j] = mk(1'b1, 1'b0, 1'b1, 8'h00, 8 - j, 1'b0, j == 8, 1'b1, 8'(8'h10 + j));
        vecs[17] = mk(1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h18);

        for (int k = 0; k < 18; k++) begin
            step(vecs[k].rst_n, vecs[k].clr, vecs[k].en, vecs[k].psh, vecs[k].pp, vecs[k].din);
            check($sformatf("vec%0d.count", k), cnt0, vecs[k].cnt);
            check($sformatf("vec%0d.flags", k),
                  {full0, empty0, af0, ae0, pl0, ppl0},
                  {vecs[k].full, vecs[k].empty, vecs[k].af, vecs[k].ae, vecs[k].pl, vecs[k].ppl});
            check($sformatf("vec%0d.out_valid", k), ov0, vecs[k].valid);
            check($sformatf("vec%0d.out_data", k), od0, vecs[k].dout);
        end

        // Overflow, then push+pop on a full FIFO; 0xBB must come out last.
        for (int i = 0; i < 8; i++) step(1, 0, 1, 1, 0, 8'(8'h21 + i));
        step(1, 0, 1, 1, 0, 8'hAA);
        check("ovf.flag", ovf0, 1'b1);
        check("ovf.count", cnt0, 8);
        step(1, 0, 1, 1, 1, 8'hBB);
        check("fullrw.count", cnt0, 8);
        check("fullrw.data", od0, 8'h21);
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 1, 0, 1, 8'h00);
            last_word = od0;
        end
        check("fullrw.last", last_word, 8'hBB);

        // Underflow, push+pop on empty, then clear.
        step(1, 0, 1, 0, 1, 8'h00);
        check("unf.flag", unf0, 1'b1);
        check("unf.out_valid", ov0, 1'b0);
        step(1, 0, 1, 1, 1, 8'h55);
        check("unf_push.count", cnt0, 1);
        check("unf_push.sticky", unf0, 1'b1);
        step(1, 1, 1, 0, 0, 8'h00);
        check("clear.errs", {ovf0, unf0}, 2'b00);
        check("clear.count", cnt0, 0);
        check("clear.ready", rdy0, 1'b0);
        step(1, 0, 1, 0, 0, 8'h00);
        check("clear.ready_back", rdy0, 1'b1);

        // Wrap-around: push then pop, 20 times.
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 1, 1, 0, 8'(i));
            check("wrap.count1", cnt0, 1);
            step(1, 0, 1, 0, 1, 8'h00);
            check("wrap.data", od0, 8'(i));
            check("wrap.count0", cnt0, 0);
        end
        check("wrap.errs", {ovf0, unf0}, 2'b00);

        // FWFT behaviour.
        step(1, 0, 1, 1, 0, 8'h3C);
        check("fwft.show_valid", ov1, 1'b1);
        check("fwft.show_data", od1, 8'h3C);
        step(1, 0, 1, 0, 1, 8'h00);
        check("fwft.pop_valid", ov1, 1'b0);
        step(1, 0, 1, 1, 0, 8'h01);
        step(1, 0, 1, 1, 0, 8'h02);
        check("fwft.head1", od1, 8'h01);
        step(1, 0, 1, 0, 1, 8'h00);
        check("fwft.head2", od1, 8'h02);
        step(1, 0, 1, 0, 1, 8'h00);

        // enable=0 freezes state; then reset at count 5.
        for (int i = 0; i < 5; i++) step(1, 0, 1, 1, 0, 8'(8'h60 + i));
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, i[0], ~i[0], 8'hEE);
            check("hold.count", cnt0, 5);
        end
        step(0, 0, 1, 1, 1, 8'h77);
        check("rst5.count", cnt0, 0);
        check("rst5.ready", rdy0, 1'b0);
        check("rst5.out", {ov0, od0}, 9'h000);

        // Randomized run with occasional reset, clear and enable drop.
        for (int k = 0; k < 3000; k++) begin
            logic bias_fill;
            bias_fill = ((k / 200) % 2) == 0;
            step($urandom_range(0, 199) != 0,
                 $urandom_range(0, 79) == 0,
                 $urandom_range(0, 9) != 0,
                 bias_fill ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                 bias_fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
